run_ctrl: RTL and testbench

- Run controller that sequences the 16-bit fst core for a host or debug front-end.
- Owns the core's reset and clock-enable.
- Provides start, stop and single-step control.
- Detects is_halt and reports a cycle count.
- Sits between the top-level host interface and the core; imem and dmem are unaffected.

---
 rtl/run_ctrl_pkg.sv | 20 ++
 rtl/run_ctrl_sat_counter.sv | 35 +++
 rtl/run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_run_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and constants for the run controller.
//   run_state_t : controller states (IDLE, CRST, RUN, PAUSE, STEP, HALT)
//   RST_CNT_W   : width of the core-reset hold down-counter
// ----------------------------------------------------------------------------
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CRST  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        STEP  = 3'd4,
        HALT  = 3'd5
    } run_state_t;

    localparam int RST_CNT_W = 8;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Parameters:
//   W      : counter width
// Ports:
//   clk    in  : clock, rising edge
//   reset  in  : asynchronous active-low reset (count -> 0)
//   clear  in  : synchronous clear, wins over enable
//   enable in  : increment by one when not already saturated
//   count  out : current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Clear has priority so a restart always begins from zero; once all-ones
    // is reached the count holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// ----------------------------------------------------------------------------
// run_ctrl
// Run controller sequencing the 16-bit fst core: owns the core reset and
// clock enable, provides start / stop / single-step, detects halt and counts
// enabled core cycles.
// Optional feature macro: RUN_WDT_EN (watchdog forcing HALT after WDT_LIMIT
// enabled cycles without a halt; wdt_expired tied to 0 when undefined).
// Parameters:
//   CNT_W      : width of cycle_cnt
//   RST_CYCLES : cycles core_reset is held on a start from IDLE/HALT (1..255)
//   WDT_LIMIT  : watchdog threshold in enabled cycles (RUN_WDT_EN only)
// Ports:
//   clk         in  : system clock, rising edge
//   reset       in  : asynchronous active-low reset
//   start_req   in  : pulse, start / resume / restart
//   stop_req    in  : pulse, pause
//   step_req    in  : pulse, one core cycle while paused
//   is_halt     in  : halt indication from the core
//   core_reset  out : active-high core reset
//   core_en     out : core clock enable
//   running     out : 1 in RUN
//   halted      out : 1 in HALT
//   step_done   out : one-cycle pulse after each step
//   cycle_cnt   out : enabled core cycles since last full start (saturating)
//   wdt_expired out : sticky watchdog flag
// ----------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 3,
    parameter int WDT_LIMIT  = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic             is_halt,
    output logic             core_reset,
    output logic             core_en,
    output logic             running,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             wdt_expired
);

    if ((RST_CYCLES < 1) || (RST_CYCLES > 255) || (WDT_LIMIT < 1)) begin : g_bad_param
        $error("run_ctrl: illegal parameter value");
    end

    run_state_t             state;
    run_state_t             state_next;
    logic [RST_CNT_W-1:0]   rst_cnt;
    logic                   enter_crst;
    logic                   wdt_hit;

    // Outputs decode only from registered state, so no request input has a
    // combinational path to any output.
    assign core_reset = (state == IDLE) || (state == CRST);
    assign core_en    = (state == RUN)  || (state == STEP);
    assign running    = (state == RUN);
    assign halted     = (state == HALT);

    // A full (re)start: cycle count, watchdog flag and reset hold all restart.
    assign enter_crst = (state_next == CRST) && (state != CRST);

`ifdef RUN_WDT_EN
    localparam logic [CNT_W-1:0] WDT_TH = CNT_W'(WDT_LIMIT - 1);

    // Compare with >= so a count pushed past the threshold by steps while
    // paused still trips on the first resumed RUN cycle.
    assign wdt_hit = (state == RUN) && !is_halt && (cycle_cnt >= WDT_TH);

    // Sticky until the next full restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_expired <= 1'b0;
        end else if (enter_crst) begin
            wdt_expired <= 1'b0;
        end else if (wdt_hit) begin
            wdt_expired <= 1'b1;
        end
    end
`else
    assign wdt_hit     = 1'b0;
    assign wdt_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Priority order inside RUN and PAUSE matters when
    // several inputs are active on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_req) state_next = CRST;
            end
            CRST: begin
                if (rst_cnt == '0) state_next = RUN;
            end
            RUN: begin
                if (is_halt)       state_next = HALT;
                else if (wdt_hit)  state_next = HALT;
                else if (stop_req) state_next = PAUSE;
            end
            PAUSE: begin
                if (stop_req)       state_next = PAUSE;
                else if (step_req)  state_next = STEP;
                else if (start_req) state_next = RUN;
            end
            STEP: begin
                state_next = is_halt ? HALT : PAUSE;
            end
            HALT: begin
                if (start_req) state_next = CRST;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset-hold counter: loaded with RST_CYCLES-1 on entry so CRST lasts
    // exactly RST_CYCLES cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt <= '0;
        end else if (enter_crst) begin
            rst_cnt <= RST_CNT_W'(RST_CYCLES - 1);
        end else if ((state == CRST) && (rst_cnt != '0)) begin
            rst_cnt <= rst_cnt - RST_CNT_W'(1);
        end
    end

    // step_done follows the single STEP cycle by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_done <= 1'b0;
        end else begin
            step_done <= (state == STEP);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (enter_crst),
        .enable (core_en),
        .count  (cycle_cnt)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_run_ctrl
// Self-checking bench for run_ctrl: directed scenarios with literal
// expectations followed by randomized request traffic, all checked every
// cycle against a behavioural model of the controller.
// ----------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int CNT_W      = 6;
    localparam int RST_CYCLES = 3;
    localparam int WDT_LIMIT  = 50;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

`ifdef RUN_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_CRST  = 1;
    localparam int P_RUN   = 2;
    localparam int P_PAUSE = 3;
    localparam int P_STEP  = 4;
    localparam int P_HALT  = 5;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             start_req = 1'b0;
    logic             stop_req  = 1'b0;
    logic             step_req  = 1'b0;
    logic             is_halt   = 1'b0;
    logic             core_reset;
    logic             core_en;
    logic             running;
    logic             halted;
    logic             step_done;
    logic [CNT_W-1:0] cycle_cnt;
    logic             wdt_expired;

    int checks    = 0;
    int failures  = 0;
    int en_seen   = 0;
    int done_seen = 0;

    // Model of the controller: phase, remaining reset cycles, count, flags.
    int m_phase     = P_IDLE;
    int m_rst_left  = 0;
    int m_cnt       = 0;
    int m_step_done = 0;
    int m_wdt       = 0;

    run_ctrl #(
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES),
        .WDT_LIMIT  (WDT_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_req   (start_req),
        .stop_req    (stop_req),
        .step_req    (step_req),
        .is_halt     (is_halt),
        .core_reset  (core_reset),
        .core_en     (core_en),
        .running     (running),
        .halted      (halted),
        .step_done   (step_done),
        .cycle_cnt   (cycle_cnt),
        .wdt_expired (wdt_expired)
    );

    always #5 clk = ~clk;

    // Behavioural model, advanced on every rising edge; reset is asynchronous.
    always @(posedge clk or negedge reset) begin : model
        int old_cnt;
        if (!reset) begin
            m_phase     = P_IDLE;
            m_rst_left  = 0;
            m_cnt       = 0;
            m_step_done = 0;
            m_wdt       = 0;
        end else begin
            old_cnt     = m_cnt;
            m_step_done = (m_phase == P_STEP) ? 1 : 0;
            if (m_phase == P_RUN || m_phase == P_STEP)
                m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            case (m_phase)
                P_IDLE, P_HALT: begin
                    if (start_req) begin
                        m_phase    = P_CRST;
                        m_rst_left = RST_CYCLES;
                        m_cnt      = 0;
                        m_wdt      = 0;
                    end
                end
                P_CRST: begin
                    m_rst_left = m_rst_left - 1;
                    if (m_rst_left == 0) m_phase = P_RUN;
                end
                P_RUN: begin
                    if (is_halt) m_phase = P_HALT;
                    else if (WDT_ON && old_cnt >= WDT_LIMIT - 1) begin
                        m_phase = P_HALT;
                        m_wdt   = 1;
                    end
                    else if (stop_req) m_phase = P_PAUSE;
                end
                P_PAUSE: begin
                    if (stop_req) m_phase = P_PAUSE;
                    else if (step_req) m_phase = P_STEP;
                    else if (start_req) m_phase = P_RUN;
                end
                P_STEP: m_phase = is_halt ? P_HALT : P_PAUSE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("core_reset", core_reset, (m_phase == P_IDLE || m_phase == P_CRST) ? 1 : 0);
        checkOutput("core_en", core_en, (m_phase == P_RUN || m_phase == P_STEP) ? 1 : 0);
        checkOutput("running", running, (m_phase == P_RUN) ? 1 : 0);
        checkOutput("halted", halted, (m_phase == P_HALT) ? 1 : 0);
        checkOutput("step_done", step_done, m_step_done);
        checkOutput("cycle_cnt", cycle_cnt, m_cnt);
        checkOutput("wdt_expired", wdt_expired, m_wdt);
    endtask

    // Every falling edge compares the DUT with the model.
    always @(negedge clk) checkModel();

    task automatic applyStimulus(input bit st, input bit sp, input bit sq, input bit hl);
        @(negedge clk);
        start_req = st;
        stop_req  = sp;
        step_req  = sq;
        is_halt   = hl;
        en_seen   += int'(core_en);
        done_seen += int'(step_done);
    endtask

    task automatic asyncReset();
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_core_reset", core_reset, 1);
        checkOutput("rst_core_en", core_en, 0);
        checkOutput("rst_cycle_cnt", cycle_cnt, 0);
        checkOutput("rst_running", running, 0);
        checkModel();
        #4 reset = 1'b1;
    endtask

    initial begin
        #130 reset = 1'b1;

        // Reset release, then start: three reset cycles, then RUN.
        repeat (4) applyStimulus(0, 0, 0, 0);
        checkOutput("idle_core_reset", core_reset, 1);
        checkOutput("idle_core_en", core_en, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < RST_CYCLES; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("crst_core_reset", core_reset, 1);
            checkOutput("crst_core_en", core_en, 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("run_core_en", core_en, 1);
        checkOutput("run_running", running, 1);
        checkOutput("run_core_reset", core_reset, 0);
        checkOutput("run_cnt_start", cycle_cnt, 0);

        // Halt raised during the 20th enabled cycle.
        repeat (18) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_core_en", core_en, 0);
        checkOutput("halt_cnt", cycle_cnt, 20);
        repeat (10) applyStimulus(0, 1, 1, 1);
        checkOutput("halt_cnt_frozen", cycle_cnt, 20);
        checkOutput("halt_still", halted, 1);

        // Restart from HALT clears the count.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("restart_core_reset", core_reset, 1);
        checkOutput("restart_cnt", cycle_cnt, 0);
        repeat (RST_CYCLES) applyStimulus(0, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pause_core_en", core_en, 0);
        checkOutput("pause_cnt", cycle_cnt, 7);

        // Three single steps spaced four cycles apart.
        en_seen   = 0;
        done_seen = 0;
        for (int p = 0; p < 3; p++) begin
            applyStimulus(0, 0, 1, 0);
            repeat (3) applyStimulus(0, 0, 0, 0);
        end
        checkOutput("step_en_pulses", en_seen, 3);
        checkOutput("step_done_pulses", done_seen, 3);
        checkOutput("step_cnt", cycle_cnt, 10);

        // Resume without reset.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("resume_running", running, 1);
        checkOutput("resume_core_reset", core_reset, 0);
        checkOutput("resume_cnt", cycle_cnt, 10);

        // Simultaneous requests in PAUSE: stop wins.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("simul_core_en", core_en, 0);
        checkOutput("simul_running", running, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("simul_no_step", core_en, 0);
        // Halt and stop together in RUN: halt wins.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("halt_over_stop", halted, 1);

        // Mid-operation reset.
        applyStimulus(1, 0, 0, 0);
        repeat (RST_CYCLES + 5) applyStimulus(0, 0, 0, 0);
        checkOutput("pre_reset_running", running, 1);
        asyncReset();
        repeat (2) applyStimulus(0, 0, 0, 0);

        // Long run: saturation, or the watchdog when enabled.
        applyStimulus(1, 0, 0, 0);
        repeat (RST_CYCLES + 1) applyStimulus(0, 0, 0, 0);
`ifdef RUN_WDT_EN
        repeat (WDT_LIMIT) applyStimulus(0, 0, 0, 0);
        checkOutput("wdt_halted", halted, 1);
        checkOutput("wdt_flag", wdt_expired, 1);
        checkOutput("wdt_cnt", cycle_cnt, WDT_LIMIT);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wdt_cleared", wdt_expired, 0);
`else
        repeat (70) applyStimulus(0, 0, 0, 0);
        checkOutput("sat_cnt", cycle_cnt, CNT_MAX);
        checkOutput("sat_running", running, 1);
        checkOutput("wdt_off", wdt_expired, 0);
`endif

        // Randomized request traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 29) == 0,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 79) == 0);
            if ($urandom_range(0, 499) == 0) asyncReset();
        end

        applyStimulus(0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
